// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the handshaked RV32 data memory.
package mem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  // Byte lanes touched by an access of the given size at addr[1:0].
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      SIZE_B:  be = 4'b0001 << addr_lo;
      SIZE_H:  be = addr_lo[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte enables and replication,
// load lane extraction with sign/zero extension, and misalignment detection.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // NOTE: every output gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    be_o       = byte_en(size_i, addr_lo_i);
    wdata_o    = wdata_i;
    rdata_o    = 32'h0;
    misalign_o = 1'b0;
    lane_b     = 8'(rword_i >> {addr_lo_i, 3'b000});
    lane_h     = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

    case (size_i)
      SIZE_B: begin
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = unsigned_i ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      end
      SIZE_H: begin
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = unsigned_i ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
        misalign_o = addr_lo_i[0];
      end
      SIZE_W: begin
        rdata_o    = rword_i;
        misalign_o = (addr_lo_i != 2'b00);
      end
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_hs.sv
// RV32 data memory with valid/ready request/response handshake, configurable
// access latency, sub-word access and misalignment error reporting.
module data_mem_hs
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  we_q, uns_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic [31:0]           wdata_q;

  logic [31:0] mem [DEPTH];

  logic                  idle, accept, access;
  logic                  sel_we, sel_uns;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [1:0]            sel_size;
  logic [31:0]           sel_wdata, rword;
  logic [3:0]            be;
  logic [31:0]           wdata_rep, rdata_ext;
  logic                  misalign;

  assign idle   = (state_q == IDLE);
  assign accept = idle && req_valid;

  // In IDLE the live request is steered so a LATENCY==1 access can use it at the accept edge.
  assign sel_we    = idle ? req_we       : we_q;
  assign sel_addr  = idle ? req_addr     : addr_q;
  assign sel_size  = idle ? req_size     : size_q;
  assign sel_uns   = idle ? req_unsigned : uns_q;
  assign sel_wdata = idle ? req_wdata    : wdata_q;
  assign rword     = mem[sel_addr[ADDR_WIDTH-1:2]];

  mem_lane_align u_align (
    .size_i     (sel_size),
    .addr_lo_i  (sel_addr[1:0]),
    .unsigned_i (sel_uns),
    .wdata_i    (sel_wdata),
    .rword_i    (rword),
    .be_o       (be),
    .wdata_o    (wdata_rep),
    .rdata_o    (rdata_ext),
    .misalign_o (misalign)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (misalign) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else if (LATENCY == 1) begin
            access  = 1'b1;
            state_d = RESP;
            err_d   = 1'b0;
            rdata_d = sel_we ? 32'h0 : rdata_ext;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = sel_we ? 32'h0 : rdata_ext;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= SIZE_B;
      uns_q   <= 1'b0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        wdata_q <= req_wdata;
      end
    end
  end

  // NOTE: the RAM array has no reset so it maps onto plain block RAM; the
  // write is gated with rst_n so a store caught by reset is never committed.
  always_ff @(posedge clk) begin
    if (rst_n && access && sel_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[sel_addr[ADDR_WIDTH-1:2]][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  assign req_ready = idle;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_hs.sv
// Self-checking bench: three instances (LATENCY 1, 2, 4) against a byte-array reference model.
module tb_data_mem_hs;

  localparam int NDUT = 3;
  localparam int LATS [NDUT] = '{1, 2, 4};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid    [NDUT];
  logic        req_we       [NDUT];
  logic [9:0]  req_addr     [NDUT];
  logic [1:0]  req_size     [NDUT];
  logic        req_unsigned [NDUT];
  logic [31:0] req_wdata    [NDUT];
  logic        rsp_ready    [NDUT];
  wire         req_ready    [NDUT];
  wire         rsp_valid    [NDUT];
  wire  [31:0] rsp_rdata    [NDUT];
  wire         rsp_err      [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    data_mem_hs #(.ADDR_WIDTH(10), .LATENCY(LATS[g])) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid[g]),
      .req_ready    (req_ready[g]),
      .req_we       (req_we[g]),
      .req_addr     (req_addr[g]),
      .req_size     (req_size[g]),
      .req_unsigned (req_unsigned[g]),
      .req_wdata    (req_wdata[g]),
      .rsp_valid    (rsp_valid[g]),
      .rsp_ready    (rsp_ready[g]),
      .rsp_rdata    (rsp_rdata[g]),
      .rsp_err      (rsp_err[g])
    );
  end

  int errors = 0;
  int checks = 0;
  logic [7:0] model [NDUT][256];

  function automatic logic [31:0] model_load(input int d, input int addr, input logic [1:0] sz, input logic uns);
    int nb;
    longint unsigned v;
    nb = 1 << sz;
    v  = 0;
    for (int i = 0; i < nb; i++) v = v | (longint'(model[d][addr + i]) << (8 * i));
    if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 1);
    return v[31:0];
  endfunction

  task automatic txn(input int d, input logic we, input logic [9:0] addr, input logic [1:0] sz,
                     input logic uns, input logic [31:0] wd, input int hold, input string name);
    logic        err_e;
    logic [31:0] rd_e;
    int          lat_k;
    err_e = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
    rd_e  = (err_e || we) ? 32'h0 : model_load(d, int'(addr), sz, uns);
    if (we && !err_e)
      for (int i = 0; i < (1 << sz); i++) model[d][int'(addr) + i] = wd[8*i +: 8];
    lat_k = err_e ? 0 : LATS[d] - 1;

    @(negedge clk);
    checks++;
    if (req_ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL %s d%0d ready_before_accept: got %b want 1", name, d, req_ready[d]);
    end
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
    req_size[d] = sz; req_unsigned[d] = uns; req_wdata[d] = wd;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0; req_we[d] = 1'($urandom); req_addr[d] = 10'($urandom);
    req_size[d] = 2'($urandom); req_unsigned[d] = 1'($urandom); req_wdata[d] = $urandom;

    for (int k = 0; k <= lat_k; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid[d] !== (k == lat_k) || req_ready[d] !== 1'b0) begin
        errors++;
        $display("FAIL %s d%0d timing k=%0d: got valid=%b ready=%b want valid=%b ready=0",
                 name, d, k, rsp_valid[d], req_ready[d], (k == lat_k));
      end
    end
    checks++;
    if (rsp_rdata[d] !== rd_e || rsp_err[d] !== err_e) begin
      errors++;
      $display("FAIL %s d%0d response: got rdata=%h err=%b want rdata=%h err=%b",
               name, d, rsp_rdata[d], rsp_err[d], rd_e, err_e);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid[d] !== 1'b1 || req_ready[d] !== 1'b0 || rsp_rdata[d] !== rd_e || rsp_err[d] !== err_e) begin
        errors++;
        $display("FAIL %s d%0d hold%0d: got valid=%b ready=%b rdata=%h err=%b want 1 0 %h %b",
                 name, d, h, rsp_valid[d], req_ready[d], rsp_rdata[d], rsp_err[d], rd_e, err_e);
      end
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[d] = 1'b0;
    checks++;
    if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1 || rsp_rdata[d] !== 32'h0 || rsp_err[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s d%0d release: got valid=%b ready=%b rdata=%h err=%b want 0 1 0 0",
               name, d, rsp_valid[d], req_ready[d], rsp_rdata[d], rsp_err[d]);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'h0 || rsp_err[d] !== 1'b0) begin
        errors++;
        $display("FAIL %s d%0d: got ready=%b valid=%b rdata=%h err=%b want 1 0 0 0",
                 name, d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_err[d]);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_release");
  endtask

  task automatic init_mem();
    for (int d = 0; d < NDUT; d++)
      for (int w = 0; w < 64; w++)
        txn(d, 1'b1, 10'(w * 4), 2'b10, 1'b0, $urandom, 0, "init");
  endtask

  task automatic test_word(input int d);
    txn(d, 1'b1, 10'h004, 2'b10, 1'b0, 32'h12345678, 0, "st_word");
    txn(d, 1'b0, 10'h004, 2'b10, 1'b0, 32'h0, 0, "ld_word");
  endtask

  task automatic test_subword();
    txn(1, 1'b1, 10'h008, 2'b10, 1'b0, 32'h0, 0, "st_zero");
    txn(1, 1'b1, 10'h009, 2'b00, 1'b0, 32'h5555_55A5, 0, "st_byte");
    txn(1, 1'b0, 10'h009, 2'b00, 1'b0, 32'h0, 0, "ld_byte_s");
    txn(1, 1'b0, 10'h009, 2'b00, 1'b1, 32'h0, 0, "ld_byte_u");
    txn(1, 1'b0, 10'h008, 2'b10, 1'b0, 32'h0, 0, "ld_word_b");
    txn(1, 1'b1, 10'h00E, 2'b01, 1'b0, 32'h7777_8001, 0, "st_half");
    txn(1, 1'b0, 10'h00E, 2'b01, 1'b0, 32'h0, 0, "ld_half_s");
    txn(1, 1'b0, 10'h00E, 2'b01, 1'b1, 32'h0, 0, "ld_half_u");
  endtask

  task automatic test_misalign();
    txn(1, 1'b0, 10'h006, 2'b10, 1'b0, 32'h0, 0, "mis_ld_word");
    txn(1, 1'b1, 10'h011, 2'b01, 1'b0, 32'h0000_BEEF, 0, "mis_st_half");
    txn(1, 1'b0, 10'h010, 2'b10, 1'b0, 32'h0, 0, "ld_after_mis");
    txn(1, 1'b0, 10'h010, 2'b11, 1'b0, 32'h0, 0, "illegal_size");
  endtask

  task automatic test_backpressure();
    txn(1, 1'b0, 10'h004, 2'b10, 1'b0, 32'h0, 5, "backpressure");
    txn(2, 1'b0, 10'h009, 2'b00, 1'b0, 32'h0, 5, "backpressure_l4");
  endtask

  task automatic test_reset_mid();
    txn(2, 1'b1, 10'h020, 2'b10, 1'b0, 32'h0BAD_F00D, 0, "st_prior");
    @(negedge clk);
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 10'h020;
    req_size[2] = 2'b10; req_unsigned[2] = 1'b0; req_wdata[2] = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid[2] !== 1'b0 || req_ready[2] !== 1'b0) begin
      errors++;
      $display("FAIL mid_wait d2: got valid=%b ready=%b want 0 0", rsp_valid[2], req_ready[2]);
    end
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_in_wait");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    txn(2, 1'b0, 10'h020, 2'b10, 1'b0, 32'h0, 0, "ld_after_reset");
  endtask

  task automatic test_random();
    for (int d = 0; d < NDUT; d++)
      for (int n = 0; n < 60; n++)
        txn(d, 1'($urandom), 10'($urandom_range(0, 255)), 2'($urandom), 1'($urandom),
            $urandom, $urandom_range(0, 2), "random");
  endtask

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0; req_size[d] = 2'b00;
      req_unsigned[d] = 1'b0; req_wdata[d] = 32'h0; rsp_ready[d] = 1'b0;
    end
    test_reset();
    init_mem();
    test_word(1);
    test_subword();
    test_misalign();
    test_backpressure();
    test_reset_mid();
    test_word(0);
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_hs.md
Name: data_mem_hs

Overview:
- Parametrised RV32 data memory for the load/store stage; successor of the single-cycle word memory.
- Adds byte-addressed sub-word access (byte/half/word) with sign/zero extension and per-byte write enables.
- Adds a valid/ready request/response handshake, configurable access latency and misalignment error reporting.
- Sits between the LSU and the on-chip data RAM.

Parameters:
- ADDR_WIDTH, 10, byte-address width; storage depth = 2**(ADDR_WIDTH-2) words of 32 bits.
- LATENCY, 1, cycles from request acceptance to the cycle rsp_valid rises; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH  byte address
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_wdata  in  32  store data, right-aligned (value in the low bits)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes the response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  access was misaligned or used an illegal size

Behaviour:
- Reset (async assert, sync release): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- RAM contents are not reset. Reset mid-operation aborts the transaction. A store not yet committed is discarded; committed data is retained.
- States:
  - IDLE: req_ready=1.
  - WAIT: req_ready=0, counting down.
  - RESP: req_ready=0, rsp_valid=1.
- Accept: req_valid && req_ready at a rising edge (edge N) latches we, addr, size, unsigned and wdata. Inputs are ignored after acceptance.
- Error check at accept:
  - size==11, half with addr[0]!=0, or word with addr[1:0]!=0 is an error.
  - Error: go to RESP at edge N with rsp_err=1, rsp_rdata=0, no RAM write. rsp_valid is visible from edge N+1 regardless of LATENCY.
- Legal access:
  - LATENCY==1: the access happens at edge N and the block goes straight to RESP.
  - LATENCY>1: go to WAIT with counter=LATENCY-2, decrement each edge, and perform the access on the edge where counter==0, then go to RESP.
  - rsp_valid rises after edge N+LATENCY-1, i.e. visible in cycle N+LATENCY.
- Store commit:
  - Byte enables: byte -> bit addr[1:0]; half -> bits {addr[1],1},{addr[1],0}; word -> all four.
  - Data is replicated to the lanes: byte -> {4{wdata[7:0]}}, half -> {2{wdata[15:0]}}.
  - Response: rsp_err=0, rsp_rdata=0.
- Load: the word at addr[ADDR_WIDTH-1:2] is read at the access edge. The lane is selected by addr[1:0] (byte) or addr[1] (half), then sign- or zero-extended per unsigned, and registered into rsp_rdata.
- RESP: rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready. On the edge with rsp_ready=1 the block returns to IDLE and clears rsp_valid, rsp_rdata and rsp_err.
- Throughput: at most one transaction outstanding. The minimum cycle is accept, LATENCY cycles, then one IDLE cycle; no accept occurs in the same cycle as the response handshake.
- Address bits above the depth do not exist (ADDR_WIDTH defines the whole space); no wrap logic is needed.

Decomposition:
- Package mem_pkg:
  - size encodings SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10.
  - state enum IDLE/WAIT/RESP.
  - Function computing the 4-bit byte enable from size and addr[1:0].
- One combinational sub-module, mem_lane_align. It produces store byte-enable and replicated data, load lane extraction with sign/zero extension, and the misalign flag.
- The top holds the FSM, counter, request latch and RAM array.

Test Plan:
- LATENCY=2: store word 0x12345678 @0x004, then load word @0x004 -> rsp_rdata=0x12345678, rsp_err=0; rsp_valid rises in cycle N+2 after accept edge N.
- Store byte 0xA5 @0x009 over word 0 at @0x008, then load byte signed @0x009 -> 0xFFFFFFA5; load byte unsigned -> 0x000000A5; load word @0x008 -> 0x0000A500.
- Store half 0x8001 @0x00E, then load half signed @0x00E -> 0xFFFF8001; load half unsigned -> 0x00008001.
- Misaligned cases:
  - Load word @0x006 -> rsp_err=1, rsp_rdata=0, response in the cycle after accept.
  - Store half @0x011 with 0xBEEF -> rsp_err=1, and a subsequent load word @0x010 is unchanged.
- Back-pressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stay stable and req_ready stays 0; raise rsp_ready -> IDLE on the next edge.
- Assert rst_n=0 in WAIT of a store of 0xDEADBEEF @0x020 (LATENCY=4) -> outputs clear immediately and a later load @0x020 returns the prior value; LATENCY=1 rerun of scenario 1 -> rsp_valid in cycle N+1.
